// File: rtl/psum_pkg.sv
// Shared types and default sizes for the psum collector.
// Optional data clamp in the top is controlled by PSUM_COLLECTOR_RELU_EN.
package psum_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_ARRAY_ROWS = 3;
  localparam int DEF_PSUM_W     = 32;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int CNT_W          = 16;

endpackage

// File: rtl/psum_row_fifo.sv
// Single-clock FIFO for one PE row; a push into a full FIFO is kept only
// when the same cycle also pops. drop_o flags a push that was refused.
module psum_row_fifo
  import psum_pkg::*;
#(
  parameter int WIDTH = DEF_PSUM_W + DEF_ADDR_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PW1   = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign drop_o     = push_i && !do_push;
  assign pop_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW1'(do_push);
    rd_ptr_d = rd_ptr_q + PW1'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/psum_collector.sv
// Collects per-row partial sums into row FIFOs and drains them round-robin
// onto one write stream. Define PSUM_COLLECTOR_RELU_EN to clamp negative data to 0.
module psum_collector
  import psum_pkg::*;
#(
  parameter int ARRAY_ROWS = DEF_ARRAY_ROWS,
  parameter int PSUM_W     = DEF_PSUM_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ARRAY_ROWS-1:0]        psum_valid,
  input  logic [ARRAY_ROWS*PSUM_W-1:0] psum_data,
  input  logic [ARRAY_ROWS*ADDR_W-1:0] psum_addr,
  input  logic                         ctrl_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PSUM_W-1:0]            out_data,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [CNT_W-1:0]             out_count,
  output logic                         busy,
  output logic                         drain_done,
  output logic                         overflow,
  output logic [1:0]                   dbg_state
);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // once raised, out_valid and the beat payload hold until that transfer.

  localparam int ENTRY_W = PSUM_W + ADDR_W;
  localparam int RR_W    = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;
  localparam int CAND_W  = RR_W + 1;

  state_t              state_q, state_d;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic                out_valid_q, out_valid_d;
  logic [PSUM_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic                overflow_q, overflow_d;

  logic                capture_en;
  logic [ARRAY_ROWS-1:0] push_vec, pop_vec, fifo_empty, fifo_full, fifo_drop;
  logic [ENTRY_W-1:0]  fifo_dout [ARRAY_ROWS];

  logic                slot_load, handshake;
  logic                grant_found;
  logic [RR_W-1:0]     grant_idx, grant_next;
  logic [CAND_W-1:0]   cand;
  logic [PSUM_W-1:0]   grant_data, slot_data;
  logic [ADDR_W-1:0]   grant_addr;

  assign capture_en = (state_q == COLLECT) || (state_q == FLUSH);
  assign push_vec   = psum_valid & {ARRAY_ROWS{capture_en}};

  for (genvar i = 0; i < ARRAY_ROWS; i++) begin : g_row
    psum_row_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_vec[i]),
      .push_data_i ({psum_data[i*PSUM_W +: PSUM_W], psum_addr[i*ADDR_W +: ADDR_W]}),
      .pop_i       (pop_vec[i]),
      .pop_data_o  (fifo_dout[i]),
      .full_o      (fifo_full[i]),
      .empty_o     (fifo_empty[i]),
      .drop_o      (fifo_drop[i])
    );
  end

  // First non-empty row at or after the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < ARRAY_ROWS; k++) begin
      cand = {1'b0, rr_q} + CAND_W'(k);
      if (cand >= CAND_W'(ARRAY_ROWS)) cand = cand - CAND_W'(ARRAY_ROWS);
      if (!grant_found && !fifo_empty[cand[RR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[RR_W-1:0];
      end
    end
  end

  assign grant_next = (grant_idx == RR_W'(ARRAY_ROWS - 1)) ? '0 : grant_idx + RR_W'(1);
  assign grant_data = fifo_dout[grant_idx][ENTRY_W-1:ADDR_W];
  assign grant_addr = fifo_dout[grant_idx][ADDR_W-1:0];

`ifdef PSUM_COLLECTOR_RELU_EN
  assign slot_data = grant_data[PSUM_W-1] ? '0 : grant_data;
`else
  assign slot_data = grant_data;
`endif

  assign handshake = out_valid_q && out_ready;
  assign slot_load = !out_valid_q || out_ready;

  always_comb begin
    pop_vec = '0;
    if (slot_load && grant_found) pop_vec[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (ctrl_done) state_d = FLUSH;
      // Leave only when nothing is buffered, nothing is arriving, and the slot drains.
      FLUSH:   if ((&fifo_empty) && !(|push_vec) && (!out_valid_q || out_ready))
                 state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_count_d = out_count_q;
    overflow_d  = overflow_q;

    if (handshake && (out_count_q != '1)) out_count_d = out_count_q + CNT_W'(1);

    if (slot_load) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_data_d = slot_data;
        out_addr_d = grant_addr;
        rr_d       = grant_next;
      end
    end

    if (|fifo_drop) overflow_d = 1'b1;

    if ((state_q == IDLE) && start) begin
      out_count_d = '0;
      overflow_d  = 1'b0;
      rr_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_count_q <= out_count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign out_count  = out_count_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == COLLECT) || (state_q == FLUSH);
  assign drain_done = (state_q == DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed and randomized bench for psum_collector with a per-row queue model.
module tb_psum_collector;
  import psum_pkg::*;

  localparam int ROWS  = 3;
  localparam int PW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst, start, ctrl_done, out_ready;
  logic [ROWS-1:0]    psum_valid;
  logic [ROWS*PW-1:0] psum_data;
  logic [ROWS*AW-1:0] psum_addr;
  logic               out_valid, busy, drain_done, overflow;
  logic [PW-1:0]      out_data;
  logic [AW-1:0]      out_addr;
  logic [15:0]        out_count;
  logic [1:0]         dbg_state;

  psum_collector dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .psum_valid (psum_valid),
    .psum_data  (psum_data),
    .psum_addr  (psum_addr),
    .ctrl_done  (ctrl_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_count  (out_count),
    .busy       (busy),
    .drain_done (drain_done),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q [ROWS][$];
  logic [63:0] got_q [$];
  logic [31:0] dv [ROWS];
  logic [31:0] av [ROWS];
  int          pushed [ROWS];
  int          acc_cnt [ROWS];
  int          seq [ROWS];
  bit          rec_en;
  int          total_rec;
  int          drain_cnt = 0;
  int          beats_at_done = 0;
  int          hold_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d, prev_a;
  logic [31:0] exp_neg;

  function automatic logic [31:0] relu_m(input logic [31:0] d);
`ifdef PSUM_COLLECTOR_RELU_EN
    return ($signed(d) < 0) ? 32'd0 : d;
`else
    return d;
`endif
  endfunction

  // Beat recorder, stall-stability watcher and drain pulse counter.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_d || out_addr !== prev_a))
        hold_err++;
      if (out_valid && out_ready) begin
        got_q.push_back({out_addr, out_data});
        if (out_addr[31:24] < 8'd3) acc_cnt[out_addr[31:24]]++;
      end
      if (drain_done) begin
        drain_cnt++;
        beats_at_done = got_q.size();
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_a     = out_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic apply(input logic [ROWS-1:0] v);
    for (int r = 0; r < ROWS; r++) begin
      psum_data[r*PW +: PW] = dv[r];
      psum_addr[r*AW +: AW] = av[r];
      if (v[r]) begin
        pushed[r]++;
        if (rec_en) begin
          exp_q[r].push_back({av[r], relu_m(dv[r])});
          total_rec++;
        end
      end
    end
    psum_valid = v;
    tick();
    psum_valid = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_model();
    got_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      exp_q[r].delete();
      pushed[r]  = 0;
      acc_cnt[r] = 0;
    end
    total_rec = 0;
    rec_en    = 1'b1;
  endtask

  task automatic wait_done(input int exp_beats);
    int d0;
    bit seen;
    d0   = drain_cnt;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (drain_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    check("drain_seen", 64'(seen), 64'(1));
    ctrl_done = 1'b0;
    tick();
    tick();
    check("drain_pulses", 64'(drain_cnt - d0), 64'(1));
    check("beats_at_done", 64'(beats_at_done), 64'(exp_beats));
    check("busy_after", 64'(busy), 64'(0));
    check("state_after", 64'(dbg_state), 64'(IDLE));
  endtask

  task automatic check_any();
    check("beat_count", 64'(got_q.size()), 64'(total_rec));
    for (int i = 0; i < got_q.size(); i++) begin
      bit found;
      found = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        if (!found && exp_q[r].size() > 0 && exp_q[r][0] === got_q[i]) begin
          void'(exp_q[r].pop_front());
          found = 1'b1;
        end
      end
      check($sformatf("beat%0d_match", i), 64'(found), 64'(1));
    end
    for (int r = 0; r < ROWS; r++)
      check($sformatf("row%0d_leftover", r), 64'(exp_q[r].size()), 64'(0));
  endtask

  task automatic check_rr();
    logic [63:0] e;
    check("rr_beat_count", 64'(got_q.size()), 64'(total_rec));
    for (int i = 0; i < got_q.size(); i++) begin
      e = '1;
      if (exp_q[i % ROWS].size() > 0) e = exp_q[i % ROWS].pop_front();
      check($sformatf("rr_beat%0d", i), got_q[i], e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROWS-1:0] pat [5];
    logic [ROWS-1:0] v;
    int n;
    rst = 1'b1; start = 1'b0; ctrl_done = 1'b0; out_ready = 1'b1;
    psum_valid = '0; psum_data = '0; psum_addr = '0;
    for (int r = 0; r < ROWS; r++) begin
      dv[r] = '0; av[r] = '0; seq[r] = 0;
    end
    clear_model();
`ifdef PSUM_COLLECTOR_RELU_EN
    exp_neg = 32'd0;
`else
    exp_neg = 32'hFFFF_FFFB;
`endif

    // Reset values
    tick(); tick();
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_addr", 64'(out_addr), 64'(0));
    check("rst_count", 64'(out_count), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_drain", 64'(drain_done), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;

    // Captures in IDLE are ignored
    rec_en = 1'b0;
    dv[0] = 32'hDEAD; dv[1] = 32'hBEEF; dv[2] = 32'hCAFE;
    apply(3'b111);
    tick(); tick(); tick();
    check("idle_no_beat", 64'(got_q.size()), 64'(0));
    check("idle_valid", 64'(out_valid), 64'(0));

    // Controller-like stagger, ctrl_done on the last capture cycle
    clear_model();
    pat[0] = 3'b001; pat[1] = 3'b011; pat[2] = 3'b111; pat[3] = 3'b110; pat[4] = 3'b100;
    do_start();
    check("stag_busy", 64'(busy), 64'(1));
    check("stag_state", 64'(dbg_state), 64'(COLLECT));
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < ROWS; r++) begin
        dv[r] = 32'(r * 10 + k);
        av[r] = 32'(k);
      end
      if (k == 4) ctrl_done = 1'b1;
      apply(pat[k]);
    end
    wait_done(9);
    check_any();
    check("stag_count", 64'(out_count), 64'(9));
    check("stag_ovf", 64'(overflow), 64'(0));

    // Two-cycle capture-to-output latency
    clear_model();
    do_start();
    dv[0] = 32'h1234; av[0] = 32'h40;
    apply(3'b001);
    check("lat_t1_valid", 64'(out_valid), 64'(0));
    tick();
    check("lat_t2_valid", 64'(out_valid), 64'(1));
    check("lat_t2_data", 64'(out_data), 64'h1234);
    check("lat_t2_addr", 64'(out_addr), 64'h40);
    ctrl_done = 1'b1;
    wait_done(1);
    check_any();

    // Backpressure: three captures per row in COLLECT, one more in FLUSH
    clear_model();
    out_ready = 1'b0;
    do_start();
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        dv[r] = $urandom;
        av[r] = {8'(r), 24'(seq[r])};
        seq[r]++;
      end
      apply(3'b111);
    end
    ctrl_done = 1'b1;
    tick();
    check("bp_state_flush", 64'(dbg_state), 64'(FLUSH));
    for (int r = 0; r < ROWS; r++) begin
      dv[r] = $urandom;
      av[r] = {8'(r), 24'(seq[r])};
      seq[r]++;
    end
    apply(3'b111);
    repeat (5) tick();
    check("bp_valid_held", 64'(out_valid), 64'(1));
    check("bp_no_beat", 64'(got_q.size()), 64'(0));
    check("bp_ovf", 64'(overflow), 64'(0));
    out_ready = 1'b1;
    wait_done(12);
    check_rr();
    check("bp_count", 64'(out_count), 64'(12));
    check("bp_hold", 64'(hold_err), 64'(0));

    // Overflow: six pushes into row 1 while the sink stalls
    clear_model();
    out_ready = 1'b0;
    do_start();
    for (int k = 0; k < 6; k++) begin
      rec_en = (k < 5);
      dv[1] = $urandom;
      av[1] = {8'd1, 24'(seq[1])};
      seq[1]++;
      apply(3'b010);
      if (k == 4) check("ovf_before", 64'(overflow), 64'(0));
    end
    rec_en = 1'b1;
    check("ovf_set", 64'(overflow), 64'(1));
    out_ready = 1'b1;
    ctrl_done = 1'b1;
    wait_done(5);
    check_any();
    check("ovf_count", 64'(out_count), 64'(5));
    check("ovf_sticky", 64'(overflow), 64'(1));
    clear_model();
    do_start();
    check("ovf_cleared", 64'(overflow), 64'(0));
    check("count_cleared", 64'(out_count), 64'(0));
    ctrl_done = 1'b1;
    wait_done(0);

    // Randomized traffic with random sink stalls
    clear_model();
    do_start();
    for (int c = 0; c < 200; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      v = '0;
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(0, 2) == 0 && (pushed[r] - acc_cnt[r]) < DEPTH) begin
          v[r]  = 1'b1;
          dv[r] = $urandom;
          av[r] = {8'(r), 24'(seq[r])};
          seq[r]++;
        end
      end
      if (c == 199) ctrl_done = 1'b1;
      apply(v);
    end
    out_ready = 1'b1;
    n = total_rec;
    wait_done(n);
    check_any();
    check("rand_count", 64'(out_count), 64'(n));
    check("rand_ovf", 64'(overflow), 64'(0));

    // Negative and positive data through the output slot
    clear_model();
    do_start();
    dv[0] = 32'hFFFF_FFFB; av[0] = 32'h10;
    dv[1] = 32'd7;         av[1] = 32'h11;
    ctrl_done = 1'b1;
    apply(3'b011);
    wait_done(2);
    check("relu_beats", 64'(got_q.size()), 64'(2));
    if (got_q.size() >= 2) begin
      check("relu_neg_data", 64'(got_q[0][31:0]), 64'(exp_neg));
      check("relu_neg_addr", 64'(got_q[0][63:32]), 64'h10);
      check("relu_pos_data", 64'(got_q[1][31:0]), 64'd7);
      check("relu_pos_addr", 64'(got_q[1][63:32]), 64'h11);
    end

    // Reset in FLUSH with two entries buffered
    clear_model();
    rec_en = 1'b0;
    out_ready = 1'b0;
    do_start();
    for (int k = 0; k < 3; k++) begin
      dv[0] = 32'(100 + k); av[0] = 32'(k);
      apply(3'b001);
    end
    ctrl_done = 1'b1;
    tick();
    check("mid_state_flush", 64'(dbg_state), 64'(FLUSH));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ctrl_done = 1'b0;
    check("mid_valid", 64'(out_valid), 64'(0));
    check("mid_data", 64'(out_data), 64'(0));
    check("mid_addr", 64'(out_addr), 64'(0));
    check("mid_count", 64'(out_count), 64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_drain", 64'(drain_done), 64'(0));
    check("mid_ovf", 64'(overflow), 64'(0));
    check("mid_state", 64'(dbg_state), 64'(IDLE));
    out_ready = 1'b1;
    repeat (10) tick();
    check("mid_no_beat", 64'(got_q.size()), 64'(0));
    check("mid_valid_late", 64'(out_valid), 64'(0));
    check("hold_total", 64'(hold_err), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sink end of the PE-array psum interface. Captures per-row partial sums whenever the array controller asserts psum_valid[i], together with the controller-issued psum_addr[i].
- Buffers each row in its own FIFO and drains all rows round-robin onto one valid/ready write stream toward output block RAM.
- Signals drain_done once the controller reports done and every captured psum has been written out.

Parameters:
- ARRAY_ROWS, 3, number of PE rows and psum lanes.
- PSUM_W, 32, psum data width (signed two's complement).
- ADDR_W, 32, psum address width.
- FIFO_DEPTH, 4, entries per row FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  pulse; arms the collector for one matrix pass.
- psum_valid  in  ARRAY_ROWS  per-row capture strobe from controller.
- psum_data  in  ARRAY_ROWS x PSUM_W  per-row psum from the bottom/edge PE.
- psum_addr  in  ARRAY_ROWS x ADDR_W  per-row write address from controller.
- ctrl_done  in  1  controller done level.
- out_valid  out  1  write beat valid.
- out_ready  in  1  sink accepts beat.
- out_data  out  PSUM_W  beat data.
- out_addr  out  ADDR_W  beat address.
- out_count  out  16  beats accepted since start.
- busy  out  1  high in COLLECT and FLUSH.
- drain_done  out  1  one-cycle pulse.
- overflow  out  1  sticky; a capture was dropped.

Interface: single clock clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset (rst high at a posedge): state IDLE; all FIFOs emptied; RR pointer 0. Outputs out_valid, out_data, out_addr, out_count, busy, drain_done and overflow are all 0. Reset mid-pass discards all buffered data with no beat emitted.
- States: IDLE, COLLECT, FLUSH, DONE.
- IDLE:
  - psum_valid is ignored.
  - start -> COLLECT. On the same edge: clear out_count and overflow, set RR pointer to 0.
- COLLECT:
  - Each row with psum_valid[i]=1 pushes {psum_data[i], psum_addr[i]} at the clock edge.
  - ctrl_done=1 -> FLUSH. Captures on that same cycle are still taken.
- FLUSH:
  - Captures are still accepted.
  - Go to DONE when all FIFOs are empty and out_valid=0 (or the final beat is accepted this cycle).
- DONE:
  - drain_done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Push rule:
  - Push into a full FIFO is accepted only if that FIFO is popped in the same cycle.
  - Otherwise the entry is dropped and overflow is set; it stays set until the next start or rst.
- Output stage is a registered skid-free slot:
  - Load the slot when it is empty, or when out_valid && out_ready.
  - The source is the first non-empty FIFO at or after the RR pointer. The pointer then moves to granted row + 1, modulo ARRAY_ROWS.
  - While out_valid=1 and out_ready=0, out_data and out_addr hold stable. out_valid never drops without a handshake.
- Latency: psum_valid in cycle t with empty FIFOs and an empty slot -> out_valid high in cycle t+2. Sustained throughput is 1 beat/cycle with out_ready held high.
- out_count increments on each out_valid && out_ready and saturates at 16'hFFFF.
- Captures from different rows in the same cycle are all taken (independent FIFOs).

Optional Feature:
- Macro PSUM_COLLECTOR_RELU_EN.
- Defined: the output slot loads max(psum,0), so a negative signed psum becomes 0.
- Undefined: data passes unmodified.
- Addresses and counts are unaffected in both cases.

Decomposition:
- psum_pkg holds the state_t enum {IDLE, COLLECT, FLUSH, DONE}, the default widths, and the out_count width constant.
- Sub-module psum_row_fifo: synchronous single-clock FIFO with push, pop, full, empty and simultaneous push/pop on full. Instantiated ARRAY_ROWS times.

Test Plan:
- Controller-like stagger, out_ready=1: start; psum_valid 100,110,111,011,001 with data row*10+k and addr k. -> 9 beats, out_count=9, overflow=0, drain_done pulses once after FLUSH empties.
- Latency: single psum_valid[0] at cycle 5 with data 0x1234 -> out_valid at cycle 7 with out_data 0x1234.
- Backpressure: out_ready=0 for 10 cycles while 3 captures per row arrive. -> out_data stable and no overflow (FIFO_DEPTH=4); order is row0,row1,row2 round-robin after release.
- Overflow: 6 pushes into row 1 with out_ready=0. -> overflow=1, exactly 4 entries buffered plus 1 in the slot, out_count=5 at the end; start clears overflow.
- Reset mid-pass: rst in FLUSH with 2 entries buffered. -> next cycle all outputs are 0 and state is IDLE; no beat appears afterwards.
- RELU: with PSUM_COLLECTOR_RELU_EN, psum -5 -> out_data 0 and +7 -> 7. Without the macro, -5 passes as 32'hFFFFFFFB.
